// File: rtl/otbn_bignum_mul_seq.sv
// Sequencer that drives otbn_mac_bignum through the 16-step MULQACC schedule
// to form the full 512-bit product of two 256-bit operands.
package otbn_bignum_mul_seq_pkg;
    parameter int WLEN = 256;

    typedef struct packed {
        logic [WLEN-1:0] operand_a;
        logic [WLEN-1:0] operand_b;
        logic [1:0]      operand_a_qw_sel;
        logic [1:0]      operand_b_qw_sel;
        logic            wr_hw_sel_upper;
        logic [1:0]      pre_acc_shift_imm;
        logic            zero_acc;
        logic            shift_acc;
    } mac_bignum_operation_t;
endpackage

module otbn_bignum_mul_seq
    import otbn_bignum_mul_seq_pkg::*;
#(
    parameter logic WipeOnAbort = 1'b1,
    parameter logic WipeOnDone  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [WLEN-1:0]       operand_a_i,
    input  logic [WLEN-1:0]       operand_b_i,
    input  logic                  stall_i,
    input  logic                  abort_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output mac_bignum_operation_t mac_operation_o,
    output logic                  mac_en_o,
    input  logic [WLEN-1:0]       mac_operation_result_i,
    output logic                  done_o,
    output logic [2*WLEN-1:0]     result_o
);
    localparam int HWLEN = WLEN / 2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q;
    logic [3:0]        step_q;
    logic [WLEN-1:0]   op_a_q, op_b_q;
    logic [2*WLEN-1:0] result_q;
    logic              accept;

    logic [1:0] aqw, bqw, shift, slot;
    logic       zacc, so, upper;

    assign ready_o  = (state_q == StIdle);
    assign busy_o   = (state_q != StIdle);
    assign accept   = start_i & ready_o & ~abort_i;
    assign mac_en_o = (state_q == StRun) & ~stall_i & ~abort_i;
    assign done_o   = (state_q == StDone) & ~abort_i;
    assign result_o = result_q;

    // Only the low half of each SO step's sum leaves the MAC; the rest stays in ACC.
    logic unused_result_hi;
    assign unused_result_hi = ^mac_operation_result_i[WLEN-1:HWLEN];

    // Schedule: quarter-word selects, pre-shift, and which result half-word an SO step fills.
    always_comb begin
        {aqw, bqw, shift, zacc, so, upper, slot} = '0;
        case (step_q)
            4'd0:  {aqw, bqw, shift, zacc} = {2'd0, 2'd0, 2'd0, 1'b1};
            4'd1:  {aqw, bqw, shift} = {2'd1, 2'd0, 2'd1};
            4'd2:  {aqw, bqw, shift, so, upper, slot} = {2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0};
            4'd3:  {aqw, bqw, shift} = {2'd2, 2'd0, 2'd0};
            4'd4:  {aqw, bqw, shift} = {2'd1, 2'd1, 2'd0};
            4'd5:  {aqw, bqw, shift} = {2'd0, 2'd2, 2'd0};
            4'd6:  {aqw, bqw, shift} = {2'd3, 2'd0, 2'd1};
            4'd7:  {aqw, bqw, shift} = {2'd2, 2'd1, 2'd1};
            4'd8:  {aqw, bqw, shift} = {2'd1, 2'd2, 2'd1};
            4'd9:  {aqw, bqw, shift, so, upper, slot} = {2'd0, 2'd3, 2'd1, 1'b1, 1'b1, 2'd1};
            4'd10: {aqw, bqw, shift} = {2'd3, 2'd1, 2'd0};
            4'd11: {aqw, bqw, shift} = {2'd2, 2'd2, 2'd0};
            4'd12: {aqw, bqw, shift} = {2'd1, 2'd3, 2'd0};
            4'd13: {aqw, bqw, shift} = {2'd3, 2'd2, 2'd1};
            4'd14: {aqw, bqw, shift, so, upper, slot} = {2'd2, 2'd3, 2'd1, 1'b1, 1'b0, 2'd2};
            4'd15: {aqw, bqw, shift, so, upper, slot} = {2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 2'd3};
            default: ;
        endcase
    end

    always_comb begin
        mac_operation_o = '0;
        if (state_q == StRun) begin
            mac_operation_o.operand_a         = op_a_q;
            mac_operation_o.operand_b         = op_b_q;
            mac_operation_o.operand_a_qw_sel  = aqw;
            mac_operation_o.operand_b_qw_sel  = bqw;
            mac_operation_o.wr_hw_sel_upper   = upper;
            mac_operation_o.pre_acc_shift_imm = shift;
            mac_operation_o.zero_acc          = zacc;
            mac_operation_o.shift_acc         = so;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            step_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else if (abort_i && state_q != StIdle) begin
            state_q <= StIdle;
            step_q  <= '0;
            if (WipeOnAbort) begin
                op_a_q   <= '0;
                op_b_q   <= '0;
                result_q <= '0;
            end
        end else begin
            case (state_q)
                StIdle: if (accept) begin
                    state_q  <= StRun;
                    step_q   <= '0;
                    op_a_q   <= operand_a_i;
                    op_b_q   <= operand_b_i;
                    result_q <= '0;
                end
                StRun: if (mac_en_o) begin
                    step_q <= step_q + 4'd1;
                    if (so) begin
                        case (slot)
                            2'd0:    result_q[1*HWLEN-1:0*HWLEN] <= mac_operation_result_i[HWLEN-1:0];
                            2'd1:    result_q[2*HWLEN-1:1*HWLEN] <= mac_operation_result_i[HWLEN-1:0];
                            2'd2:    result_q[3*HWLEN-1:2*HWLEN] <= mac_operation_result_i[HWLEN-1:0];
                            default: result_q[4*HWLEN-1:3*HWLEN] <= mac_operation_result_i[HWLEN-1:0];
                        endcase
                    end
                    if (step_q == 4'd15) begin
                        state_q <= StDone;
                        if (WipeOnDone) begin
                            op_a_q <= '0;
                            op_b_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Cycles since the most recent accept, saturating; only feeds the done-latency check.
    logic [4:0] acc_age_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  acc_age_q <= '0;
        else if (accept)              acc_age_q <= 5'd1;
        else if (acc_age_q != 5'd31)  acc_age_q <= acc_age_q + 5'd1;
    end

    a_en_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mac_en_o |-> (state_q == StRun));
    a_done_late: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_o |-> (acc_age_q >= 5'd16));
    a_step_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mac_en_o |-> !$isunknown(step_q));
endmodule

// File: tb/tb_otbn_bignum_mul_seq.sv
// Bench for otbn_bignum_mul_seq: a behavioural MAC plus an arithmetic model of the
// sequencer's visible behaviour, checked every cycle, with directed and random runs.
module tb_otbn_bignum_mul_seq;
    import otbn_bignum_mul_seq_pkg::*;

    logic                  clk = 1'b0, rst_ni = 1'b0;
    logic                  start_i = 1'b0, stall_i = 1'b0, abort_i = 1'b0;
    logic [WLEN-1:0]       operand_a = '0, operand_b = '0;
    mac_bignum_operation_t mac_op;
    logic                  mac_en, ready, busy, done;
    logic [WLEN-1:0]       mac_res;
    logic [2*WLEN-1:0]     result;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    otbn_bignum_mul_seq dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .operand_a_i(operand_a), .operand_b_i(operand_b),
        .stall_i(stall_i), .abort_i(abort_i), .ready_o(ready), .busy_o(busy),
        .mac_operation_o(mac_op), .mac_en_o(mac_en),
        .mac_operation_result_i(mac_res), .done_o(done), .result_o(result)
    );

    task automatic chk(input string nm, input logic [2*WLEN-1:0] act, input logic [2*WLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [2*WLEN-1:0] prod(input logic [WLEN-1:0] a, input logic [WLEN-1:0] b);
        return {{WLEN{1'b0}}, a} * {{WLEN{1'b0}}, b};
    endfunction

    function automatic logic [WLEN-1:0] rnd256();
        logic [WLEN-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural bignum MAC: ACC is not tied to the sequencer reset and starts as garbage.
    logic [WLEN-1:0] acc = {8{32'hDEADBEEF}};
    function automatic logic [WLEN-1:0] mac_fn(input mac_bignum_operation_t op, input logic [WLEN-1:0] a);
        logic [63:0]     qa, qb;
        logic [WLEN-1:0] p;
        qa = 64'(op.operand_a >> (64 * int'(op.operand_a_qw_sel)));
        qb = 64'(op.operand_b >> (64 * int'(op.operand_b_qw_sel)));
        p  = {128'b0, 128'(qa) * 128'(qb)} << (64 * int'(op.pre_acc_shift_imm));
        return (op.zero_acc ? '0 : a) + p;
    endfunction
    assign mac_res = mac_fn(mac_op, acc);
    always @(posedge clk) if (mac_en) acc <= mac_op.shift_acc ? (mac_res >> 128) : mac_res;

    // Reference model: 0 idle, 1 running (m_issued steps done), 2 done.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                m_state = 0, m_issued = 0, m_t = 0, m_stalls = 0;
    logic [WLEN-1:0]   m_a = '0, m_b = '0;
    logic [2*WLEN-1:0] m_res = '0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_state <= 0; m_issued <= 0; m_res <= '0;
        end else begin
            case (m_state)
                0: if (start_i && !abort_i) begin
                    m_state <= 1; m_issued <= 0; m_a <= operand_a; m_b <= operand_b;
                    m_t <= cyc; m_stalls <= 0; m_res <= '0;
                end
                1: if (abort_i) begin
                    m_state <= 0; m_res <= '0;
                end else if (stall_i) begin
                    m_stalls <= m_stalls + 1;
                end else begin
                    m_issued <= m_issued + 1;
                    if (m_issued == 15) m_state <= 2;
                end
                default: begin
                    m_state <= 0;
                    m_res   <= abort_i ? '0 : prod(m_a, m_b);
                end
            endcase
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    logic                  prev_stall = 1'b0;
    mac_bignum_operation_t prev_op;
    always @(negedge clk) begin
        chk1("ready", ready, m_state == 0);
        chk1("busy", busy, m_state != 0);
        chk1("mac_en", mac_en, m_state == 1 && !stall_i && !abort_i);
        chk1("done", done, m_state == 2 && !abort_i);
        if (m_state != 1) chk1("op_idle_zero", mac_op == '0, 1'b1);
        if (m_state == 1 && prev_stall) chk1("op_hold_on_stall", mac_op == prev_op, 1'b1);
        if (m_state == 0) chk("result_hold", result, m_res);
        if (m_state == 2 && !abort_i) begin
            chk("product", result, prod(m_a, m_b));
            chk("acc_zero", 512'(acc), '0);
            chk("latency", 512'(cyc - m_t), 512'(17 + m_stalls));
        end
        prev_stall <= (m_state == 1) && stall_i && !abort_i;
        prev_op    <= mac_op;
    end

    // One operation: accept, then per cycle apply stall mask / stray start / abort / reset.
    // oc: 1 done seen, 2 aborted or reset, 0 ran out of cycles.
    task automatic do_run(input logic [WLEN-1:0] a, input logic [WLEN-1:0] b, input logic [15:0] smask,
                          input int start_at, input int abort_at, input int rst_at,
                          output logic [2*WLEN-1:0] res, output int lat, output int oc);
        logic [15:0] used;
        bit          st_used, do_abort;
        used = '0; st_used = 0; res = '0; lat = 0; oc = 0;
        @(posedge clk); #1;
        operand_a = a; operand_b = b; start_i = 1'b1; stall_i = 1'b0; abort_i = 1'b0;
        @(negedge clk);
        chk1("accept_ready", ready, 1'b1);
        @(posedge clk); #1;
        for (int k = 1; k < 80 && oc == 0; k++) begin
            start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
            if (m_state == 1 && smask[m_issued] && !used[m_issued]) begin
                stall_i = 1'b1; used[m_issued] = 1'b1;
            end
            if (m_state == 1 && m_issued == start_at && !st_used) begin
                start_i = 1'b1; st_used = 1; operand_a = rnd256(); operand_b = rnd256();
            end
            do_abort = (abort_at >= 0) && ((abort_at < 16 && m_state == 1 && m_issued == abort_at) ||
                                           (abort_at == 16 && m_state == 2));
            if (do_abort) begin abort_i = 1'b1; stall_i = 1'b1; end
            if (rst_at >= 0 && m_state == 1 && m_issued == rst_at) begin
                #2 rst_ni = 1'b0;
                #1;
                chk1("rst_ready", ready, 1'b1);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_mac_en", mac_en, 1'b0);
                chk1("rst_done", done, 1'b0);
                chk("rst_result", result, '0);
                chk1("rst_op_zero", mac_op == '0, 1'b1);
                @(negedge clk); @(negedge clk);
                rst_ni = 1'b1;
                oc = 2;
            end else begin
                @(negedge clk);
                if (do_abort) begin
                    chk1("abort_mac_en", mac_en, 1'b0);
                    chk1("abort_done", done, 1'b0);
                    @(posedge clk); #1;
                    abort_i = 1'b0; stall_i = 1'b0;
                    @(negedge clk);
                    chk1("abort_ready_next", ready, 1'b1);
                    chk("abort_result_wiped", result, '0);
                    oc = 2;
                end else if (done === 1'b1) begin
                    res = result; lat = k; oc = 1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2*WLEN-1:0] res, exp;
        logic [WLEN-1:0]   a, b;
        logic [15:0]       m;
        int                lat, oc;

        repeat (2) @(negedge clk);
        chk1("reset_ready", ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_mac_en", mac_en, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_result", result, '0);
        chk1("reset_op_zero", mac_op == '0, 1'b1);
        rst_ni = 1'b1;

        // 1 * 1
        do_run(256'd1, 256'd1, 16'h0, -1, -1, -1, res, lat, oc);
        chk("one_oc", 512'(oc), 512'd1);
        chk("one_result", res, 512'd1);
        chk("one_latency", 512'(lat), 512'd17);
        chk("one_acc_zero", 512'(acc), '0);

        // all-ones operands: 2^512 - 2^257 + 1
        do_run({WLEN{1'b1}}, {WLEN{1'b1}}, 16'h0, -1, -1, -1, res, lat, oc);
        exp = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        chk("max_result", res, exp);
        chk("max_latency", 512'(lat), 512'd17);

        // five scattered stalls
        a = rnd256(); b = rnd256();
        do_run(a, b, 16'h4292, -1, -1, -1, res, lat, oc);
        chk("stall_result", res, prod(a, b));
        chk("stall_latency", 512'(lat), 512'd22);

        // abort (together with stall) at step 7, then 3 * 5
        do_run(rnd256(), rnd256(), 16'h0, -1, 7, -1, res, lat, oc);
        chk("abort_oc", 512'(oc), 512'd2);
        do_run(256'd3, 256'd5, 16'h0, -1, -1, -1, res, lat, oc);
        chk("after_abort_result", res, 512'd15);
        chk("after_abort_latency", 512'(lat), 512'd17);

        // stray start at step 4 is ignored
        a = rnd256(); b = rnd256();
        do_run(a, b, 16'h0, 4, -1, -1, res, lat, oc);
        chk("busy_start_result", res, prod(a, b));
        chk("busy_start_latency", 512'(lat), 512'd17);

        // start together with abort in idle is not accepted
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1; operand_a = rnd256(); operand_b = rnd256();
        @(negedge clk);
        chk1("start_abort_ready", ready, 1'b1);
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        @(negedge clk);
        chk1("start_abort_no_busy", busy, 1'b0);
        chk("start_abort_result_kept", result, prod(a, b));

        // abort in DONE suppresses done_o
        do_run(rnd256(), rnd256(), 16'h0, -1, 16, -1, res, lat, oc);
        chk("abort_done_oc", 512'(oc), 512'd2);

        // asynchronous reset at step 10, then 2^255 * 2
        do_run(rnd256(), rnd256(), 16'h0, -1, -1, 10, res, lat, oc);
        chk("rst_oc", 512'(oc), 512'd2);
        a = '0; a[255] = 1'b1;
        exp = '0; exp[256] = 1'b1;
        do_run(a, 256'd2, 16'h0, -1, -1, -1, res, lat, oc);
        chk("after_rst_result", res, exp);
        chk("after_rst_latency", 512'(lat), 512'd17);

        // random operands with random stall masks
        for (int i = 0; i < 10; i++) begin
            a = rnd256(); b = rnd256();
            m = 16'($urandom & $urandom);
            do_run(a, b, m, -1, -1, -1, res, lat, oc);
            chk("rand_result", res, prod(a, b));
            chk("rand_latency", 512'(lat), 512'(17 + $countones(m)));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
